// File: rtl/note_stabilizer.sv
// Debounces raw note detections into a stable locked note with a silence timeout.
module note_stabilizer #(
  parameter int unsigned CLK_MHZ        = 50,
  parameter int unsigned CONFIRM_CNT    = 4,
  parameter int unsigned TIMEOUT_MS     = 200,
  parameter int unsigned TIMEOUT_CYCLES = CLK_MHZ * 1000 * TIMEOUT_MS,
  localparam int unsigned RW = $clog2(CONFIRM_CNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          note_vld,
  input  logic [3:0]    note_idx,
  output logic          stable_vld,
  output logic [3:0]    stable_note,
  output logic          note_change,
  output logic [RW-1:0] run_len
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [3:0]  NO_NOTE = 4'hF;
  localparam logic [3:0]  MAX_NOTE = 4'd11;

  typedef enum logic [0:0] {SILENT, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [RW-1:0]   run_q, run_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            vld_q, vld_d;
  logic [3:0]      note_q, note_d;
  logic            chg_q, chg_d;
  logic            valid_c;
  logic            hit_c;

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SILENT;
      cand_q  <= NO_NOTE;
      run_q   <= '0;
      timer_q <= '0;
      vld_q   <= 1'b0;
      note_q  <= NO_NOTE;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
      timer_q <= timer_d;
      vld_q   <= vld_d;
      note_q  <= note_d;
      chg_q   <= chg_d;
    end
  end

  // Candidate tracking, hold timer and lock/release decisions
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    run_d   = run_q;
    timer_d = timer_q;
    vld_d   = vld_q;
    note_d  = note_q;
    chg_d   = 1'b0;
    valid_c = note_vld && (note_idx <= MAX_NOTE);
    hit_c   = 1'b0;

    // Run length of identical valid detections, saturating at the lock threshold
    if (note_vld) begin
      if (!valid_c) begin
        cand_d = NO_NOTE;
        run_d  = '0;
      end else if (note_idx == cand_q) begin
        run_d = (run_q == RW'(CONFIRM_CNT)) ? run_q : RW'(run_q + RW'(1));
      end else begin
        cand_d = note_idx;
        run_d  = RW'(1);
      end
    end

    hit_c = valid_c && (run_d == RW'(CONFIRM_CNT));

    // Any valid detection restarts the hold window; it only counts down while locked
    if (valid_c) begin
      timer_d = TW'(TIMEOUT_CYCLES - 1);
    end else if ((state_q == LOCKED) && (timer_q != '0)) begin
      timer_d = TW'(timer_q - TW'(1));
    end

    case (state_q)
      SILENT: begin
        if (hit_c) begin
          state_d = LOCKED;
          vld_d   = 1'b1;
          note_d  = cand_d;
          chg_d   = 1'b1;
        end
      end
      LOCKED: begin
        if (hit_c) begin
          if (cand_d != note_q) begin
            note_d = cand_d;
            chg_d  = 1'b1;
          end
        end else if (!valid_c && (timer_q == '0)) begin
          state_d = SILENT;
          vld_d   = 1'b0;
          note_d  = NO_NOTE;
          chg_d   = 1'b1;
          cand_d  = NO_NOTE;
          run_d   = '0;
        end
      end
      default: state_d = SILENT;
    endcase
  end

  assign stable_vld  = vld_q;
  assign stable_note = note_q;
  assign note_change = chg_q;
  assign run_len     = run_q;

endmodule
